pdm_sample_fifo: RTL and testbench

Parametrised synchronous single-clock FIFO buffering decimated PDM samples between the CIC/decimator output and the SPI/readout side. Holds exactly DEPTH entries and reports the fill level with programmable almost-full/almost-empty thresholds. Selectable standard (registered read) or first-word-fall-through output, synchronous flush, and sticky overflow/underflow error flags.

---
 rtl/pdm_sample_fifo.sv | 111 +++++++++++
 tb/tb_pdm_sample_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pdm_sample_fifo.sv
// Single-clock sample FIFO between the PDM decimator and the readout side.
// Wrap-bit pointers, fill count with threshold flags, sticky error flags.
module pdm_sample_fifo #(
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 16,
    parameter int AFULL_LEVEL  = DEPTH - 4,
    parameter int AEMPTY_LEVEL = 4,
    parameter bit FWFT         = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         write_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         read_data_o,
    output logic                     rd_valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     almost_full_o,
    output logic                     almost_empty_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_LVL = PW'(AFULL_LEVEL);
    localparam logic [PW-1:0] AE_LVL = PW'(AEMPTY_LEVEL);
    localparam logic [PW-1:0] ONE    = PW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    count;
    logic             ovf_q;
    logic             udf_q;
    logic             rd_acc;
    logic             wr_acc;

    // Full when the slot indices match but the wrap bits differ.
    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});

    assign rd_acc = rd_en_i && !empty_o;
    assign wr_acc = wr_en_i && (!full_o || rd_acc);

    assign count_o        = count;
    assign almost_full_o  = (count >= AF_LVL);
    assign almost_empty_o = (count <= AE_LVL);
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ONE;
            if (rd_acc) rd_ptr <= rd_ptr + ONE;
            if (wr_acc && !rd_acc) begin
                count <= count + ONE;
            end else if (rd_acc && !wr_acc) begin
                count <= count - ONE;
            end
            if (wr_en_i && !wr_acc) ovf_q <= 1'b1;
            if (rd_en_i && empty_o) udf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !clear_i && wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= write_data_i;
        end
    end

    if (FWFT) begin : g_fwft
        assign read_data_o = empty_o ? '0 : mem[rd_ptr[AW-1:0]];
        assign rd_valid_o  = !empty_o;
    end else begin : g_std
        logic [WIDTH-1:0] rdata_q;
        logic             rvalid_q;

        // Read data holds between pops; a flush only drops the valid pulse.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else if (clear_i) begin
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_acc;
                if (rd_acc) rdata_q <= mem[rd_ptr[AW-1:0]];
            end
        end

        assign read_data_o = rdata_q;
        assign rd_valid_o  = rvalid_q;
    end

endmodule

// File: tb/tb_pdm_sample_fifo.sv
// Bench for pdm_sample_fifo: standard and FWFT instances share stimulus
// and are compared against a queue-based reference model.
module tb_pdm_sample_fifo;

    localparam int W = 16;
    localparam int D = 16;
    localparam int AF = 12;
    localparam int AE = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear_i = 1'b0;
    logic         wr_en_i = 1'b0;
    logic [W-1:0] write_data_i = '0;
    logic         rd_en_i = 1'b0;

    logic [W-1:0] s_rdata, f_rdata;
    logic         s_rvalid, f_rvalid;
    logic [4:0]   s_count, f_count;
    logic         s_full, f_full, s_empty, f_empty;
    logic         s_af, f_af, s_ae, f_ae;
    logic         s_ovf, f_ovf, s_udf, f_udf;

    pdm_sample_fifo #(
        .WIDTH(W), .DEPTH(D), .AFULL_LEVEL(AF),
        .AEMPTY_LEVEL(AE), .FWFT(1'b0)
    ) u_std (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_i),
        .wr_en_i(wr_en_i), .write_data_i(write_data_i),
        .rd_en_i(rd_en_i), .read_data_o(s_rdata),
        .rd_valid_o(s_rvalid), .count_o(s_count),
        .full_o(s_full), .empty_o(s_empty),
        .almost_full_o(s_af), .almost_empty_o(s_ae),
        .overflow_o(s_ovf), .underflow_o(s_udf)
    );

    pdm_sample_fifo #(
        .WIDTH(W), .DEPTH(D), .AFULL_LEVEL(AF),
        .AEMPTY_LEVEL(AE), .FWFT(1'b1)
    ) u_fwft (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_i),
        .wr_en_i(wr_en_i), .write_data_i(write_data_i),
        .rd_en_i(rd_en_i), .read_data_o(f_rdata),
        .rd_valid_o(f_rvalid), .count_o(f_count),
        .full_o(f_full), .empty_o(f_empty),
        .almost_full_o(f_af), .almost_empty_o(f_ae),
        .overflow_o(f_ovf), .underflow_o(f_udf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    logic [W-1:0] q[$];
    bit           m_ovf, m_udf, m_rv;
    logic [W-1:0] m_rd;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h, expected %0h",
                      tag, $time, got, exp);
    endtask

    task automatic model(input bit r, input bit c, input bit w,
                         input logic [W-1:0] d, input bit rd);
        bit e, f, ra, wa;
        if (!r) begin
            q.delete();
            m_ovf = 0; m_udf = 0; m_rv = 0; m_rd = '0;
        end else if (c) begin
            q.delete();
            m_ovf = 0; m_udf = 0; m_rv = 0;
        end else begin
            e  = (q.size() == 0);
            f  = (q.size() == D);
            ra = rd && !e;
            wa = w && (!f || ra);
            if (w && !wa) m_ovf = 1;
            if (rd && e) m_udf = 1;
            m_rv = ra;
            if (ra) m_rd = q.pop_front();
            if (wa) q.push_back(d);
        end
    endtask

    task automatic check_state();
        int n;
        n = q.size();
        check("s_count", 32'(s_count), 32'(n));
        check("s_full", 32'(s_full), 32'(n == D));
        check("s_empty", 32'(s_empty), 32'(n == 0));
        check("s_afull", 32'(s_af), 32'(n >= AF));
        check("s_aempty", 32'(s_ae), 32'(n <= AE));
        check("s_ovf", 32'(s_ovf), 32'(m_ovf));
        check("s_udf", 32'(s_udf), 32'(m_udf));
        check("s_rvalid", 32'(s_rvalid), 32'(m_rv));
        check("s_rdata", 32'(s_rdata), 32'(m_rd));
        check("f_count", 32'(f_count), 32'(n));
        check("f_full", 32'(f_full), 32'(n == D));
        check("f_empty", 32'(f_empty), 32'(n == 0));
        check("f_ovf", 32'(f_ovf), 32'(m_ovf));
        check("f_udf", 32'(f_udf), 32'(m_udf));
        check("f_rvalid", 32'(f_rvalid), 32'(n != 0));
        check("f_rdata", 32'(f_rdata), 32'(n != 0 ? q[0] : 16'h0));
    endtask

    task automatic step(input bit r, input bit c, input bit w,
                        input logic [W-1:0] d, input bit rd);
        rst_n = r; clear_i = c; wr_en_i = w;
        write_data_i = d; rd_en_i = rd;
        @(posedge clk);
        #1;
        model(r, c, w, d, rd);
        check_state();
    endtask

    task automatic fill(input int base);
        for (int i = 0; i < D; i++) step(1, 0, 1, W'(base + i), 0);
    endtask

    task automatic drain();
        for (int i = 0; i < D; i++) step(1, 0, 0, '0, 1);
    endtask

    initial begin
        int phase;
        bit r, c, w, rd;

        step(0, 0, 0, '0, 0);
        step(0, 0, 1, 16'h5555, 1);

        fill(0);
        check("fill_full", 32'(s_full), 32'd1);
        check("fill_count", 32'(s_count), 32'd16);
        for (int i = 0; i < D; i++) begin
            step(1, 0, 0, '0, 1);
            check("drain_order", 32'(s_rdata), 32'(i));
        end
        check("drain_empty", 32'(s_empty), 32'd1);
        check("drain_noflag", 32'({s_ovf, s_udf}), 32'd0);

        fill(16'h100);
        step(1, 0, 1, 16'hDEAD, 0);
        check("ovf_set", 32'(s_ovf), 32'd1);
        drain();
        check("ovf_last", 32'(s_rdata), 32'h10F);
        step(1, 0, 0, '0, 1);
        check("udf_set", 32'(s_udf), 32'd1);
        step(1, 1, 1, 16'h7777, 1);
        check("clr_flags", 32'({s_ovf, s_udf}), 32'd0);
        check("clr_count", 32'(s_count), 32'd0);

        fill(16'h200);
        step(1, 0, 1, 16'hABCD, 1);
        check("simul_count", 32'(s_count), 32'd16);
        check("simul_ovf", 32'(s_ovf), 32'd0);
        check("simul_out", 32'(s_rdata), 32'h200);
        drain();
        check("simul_last", 32'(s_rdata), 32'hABCD);

        step(1, 0, 1, 16'h1234, 0);
        check("fwft_data", 32'(f_rdata), 32'h1234);
        check("fwft_valid", 32'(f_rvalid), 32'd1);
        step(1, 0, 0, '0, 1);
        check("fwft_empty", 32'(f_empty), 32'd1);
        check("fwft_zero", 32'(f_rdata), 32'd0);

        for (int i = 0; i < 1000; i++) begin
            phase = (i / 40) % 3;
            r  = ($urandom_range(0, 199) != 0);
            c  = ($urandom_range(0, 149) == 0);
            case (phase)
                0: begin
                    w  = ($urandom_range(0, 9) < 8);
                    rd = ($urandom_range(0, 9) < 3);
                end
                1: begin
                    w  = ($urandom_range(0, 9) < 3);
                    rd = ($urandom_range(0, 9) < 8);
                end
                default: begin
                    w  = $urandom_range(0, 1) == 1;
                    rd = $urandom_range(0, 1) == 1;
                end
            endcase
            step(r, c, w, W'($urandom), rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
